local_eject_receiver: RTL
=========================

Name: local_eject_receiver

Overview:
Receiving end of the router link protocol (data/sent_req/new/vc_no/ready), instantiated on the router's local outport in a PE tile. Accepts phits from the router on up to no_vc interleaved virtual channels and tracks packet boundaries per VC from the header length field. Buffers phits in a FIFO for the PE sink, checks that each packet's destination matches my_addr, and keeps receive statistics.

Parameters:
no_vc, 13, number of virtual channels; vc_no 0 is valid
phit_size, 16, phit width in bits
flit_size, 1, phits per flit
buf_size, 4, FIFO depth in flits; depth in phits D = buf_size*flit_size
addr_length, 8, destination address width
addr_place_in_header, 0, LSB of destination field in the header phit
len_field_bits, 8, packet length in flits; field sits at addr_place_in_header+addr_length
my_addr, 0, this node's address

Ports:
clk  in  1  clock
full_reset  in  1  synchronous, active-low reset
data_in  in  phit_size  phit from router
sent_req_in  in  1  phit valid
new_in  in  1  phit is a packet header (first phit)
vc_no_in  in  $clog2(no_vc+1)  VC of phit
ready_out  out  1  receiver can accept a phit this cycle
pop_data  out  phit_size  FIFO head phit
pop_vc  out  $clog2(no_vc+1)  VC of head phit
pop_first  out  1  head phit is a header
pop_last  out  1  head phit is the last phit of its packet
pop_valid  out  1  FIFO non-empty
pop_ready  in  1  sink consumes the head phit
report_reset  in  1  sync active-high clear of the statistics counters
no_packet_recieve_report  out  32  packets completed
misroute_report  out  32  headers with dest != my_addr
proto_err_report  out  32  protocol violations
busy  out  1  FIFO non-empty or any VC mid-packet

Behaviour:
- Reset (full_reset=0 at posedge): FIFO empty, all VCs IDLE, all counters 0. ready_out=0 during reset and 1 on the first cycle after reset. pop_valid=0, busy=0.
- Accept: a phit is accepted when sent_req_in && ready_out. vc_no_in > no_vc-1 is a protocol error and the phit is dropped.
- ready_out is registered: ready_out <= (next FIFO count < D). Count changes only through accepted pushes and pops (pop_valid && pop_ready). Push and pop in the same cycle leave the count unchanged.
- Per-VC FSM, indexed by vc_no_in:
  - IDLE + new_in=1: load rem = max(len,1)*flit_size - 1. Compare the dest field to my_addr; on mismatch, misroute_report++ (phit still stored). If rem==0, tag pop_last and stay IDLE; else go to BODY.
  - IDLE + new_in=0: proto_err_report++; phit dropped, not stored.
  - BODY + new_in=0: store the phit and decrement rem. When rem reaches 0, tag pop_last, no_packet_recieve_report++, and return to IDLE.
  - BODY + new_in=1: proto_err_report++; the partial packet is abandoned, and the new header is processed as if the VC were IDLE.
  - A single-phit packet also increments no_packet_recieve_report on acceptance.
- FIFO entry = {data, vc, first, last}; first-word-fall-through; pop outputs are valid whenever pop_valid=1.
- Latency: an accepted phit appears on pop_* the next cycle if the FIFO was empty.
- Counters saturate at 2^32-1. report_reset clears the counters only. A packet completion in the same cycle as report_reset leaves the counter at 0.
- Reset mid-packet discards all FIFO contents and VC state.

Decomposition:
- Shared package (noc_pkg): VC state enum {IDLE, BODY}, FIFO entry struct, and header field offset helper functions.
- One natural sub-module: phit_fifo (parameterised depth/width, FWFT, count output).

Test Plan:
- 1: Reset, then header on VC 2 with dest=my_addr and len=3 (flit_size 1), followed by 2 body phits -> pop sequence first,-,last on vc 2; no_packet_recieve_report=1.
- 2: Interleave VC 0 and VC 5 packets of len 2 phit-by-phit -> per-VC first/last tags correct; report=2; proto_err_report=0.
- 3: pop_ready=0 with continuous sent_req (D=4) -> exactly 4 phits accepted; ready_out=0 from the cycle after the 4th; one pop restores ready_out the following cycle; no data lost.
- 4: Header dest=my_addr+1 -> misroute_report=1; packet still delivered.
- 5: Body phit on an IDLE VC -> dropped, proto_err_report=1. New header mid-packet -> proto_err_report=2, and the new packet completes normally.
- 6: full_reset low mid-packet with the FIFO at 3 phits -> pop_valid=0 and ready_out=0 during reset; ready_out=1 and counters 0 after release.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared types and header-field helpers for the local eject receiver.
package noc_pkg;
  localparam int NO_VC = 13;
  localparam int PHIT_SIZE = 16;
  localparam int VC_W = $clog2(NO_VC + 1);
  typedef enum logic {IDLE, BODY} vc_state_t;
  typedef struct packed {
    logic [PHIT_SIZE-1:0] data;
    logic [VC_W-1:0]      vc;
    logic                 first;
    logic                 last;
  } entry_t;
  function automatic int dest_lsb(int addr_place);
    return addr_place;
  endfunction
  function automatic int len_lsb(int addr_place, int addr_length);
    return addr_place + addr_length;
  endfunction
  function automatic logic [31:0] sat_inc(logic [31:0] c, logic en);
    return (en && c != '1) ? c + 32'd1 : c;
  endfunction
endpackage

// File: rtl/phit_fifo.sv
// phit_fifo: first-word-fall-through FIFO with occupancy count, sync active-low reset.
module phit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  assign o_data = r_mem[r_rd];
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
      if (i_pop) r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
endmodule

// File: rtl/local_eject_receiver.sv
// local_eject_receiver: router local-port sink; per-VC packet tracking, FWFT buffer, receive statistics.
module local_eject_receiver
  import noc_pkg::*;
#(
  parameter int no_vc = NO_VC,
  parameter int phit_size = PHIT_SIZE,
  parameter int flit_size = 1,
  parameter int buf_size = 4,
  parameter int addr_length = 8,
  parameter int addr_place_in_header = 0,
  parameter int len_field_bits = 8,
  parameter int my_addr = 0
) (
  input  logic                         clk,
  input  logic                         full_reset,
  input  logic [phit_size-1:0]         data_in,
  input  logic                         sent_req_in,
  input  logic                         new_in,
  input  logic [$clog2(no_vc+1)-1:0]   vc_no_in,
  output logic                         ready_out,
  output logic [phit_size-1:0]         pop_data,
  output logic [$clog2(no_vc+1)-1:0]   pop_vc,
  output logic                         pop_first,
  output logic                         pop_last,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  input  logic                         report_reset,
  output logic [31:0]                  no_packet_recieve_report,
  output logic [31:0]                  misroute_report,
  output logic [31:0]                  proto_err_report,
  output logic                         busy
);
  localparam int D = buf_size * flit_size;
  localparam int CW = $clog2(D + 1);
  localparam int VW = $clog2(no_vc + 1);
  localparam int RW = len_field_bits + $clog2(flit_size + 1);
  localparam int DL = dest_lsb(addr_place_in_header);
  localparam int LL = len_lsb(addr_place_in_header, addr_length);
  vc_state_t r_state [no_vc];
  vc_state_t w_state_n [no_vc];
  logic [RW-1:0] r_rem [no_vc];
  logic [RW-1:0] w_rem_n [no_vc];
  logic r_ready;
  logic [31:0] r_pkt, r_mis, r_err;
  logic [CW-1:0] w_count, w_next_count;
  logic [len_field_bits-1:0] w_len;
  logic [RW-1:0] w_hdr_rem;
  logic [VW-1:0] w_idx;
  logic w_vc_ok, w_acc, w_hdr, w_body, w_push, w_pop, w_last, w_proto, w_mis, w_empty, w_any_body;
  vc_state_t w_cur;
  entry_t w_entry, w_head;
  assign w_acc = sent_req_in && ready_out;
  assign w_vc_ok = int'(vc_no_in) < no_vc;
  assign w_idx = w_vc_ok ? vc_no_in : '0;
  assign w_cur = r_state[w_idx];
  assign w_len = data_in[LL +: len_field_bits];
  // A zero length field is treated as a one-flit packet.
  assign w_hdr_rem = RW'((w_len == '0 ? 1 : int'(w_len)) * flit_size - 1);
  assign w_hdr = w_acc && w_vc_ok && new_in;
  assign w_body = w_acc && w_vc_ok && !new_in && w_cur == BODY;
  assign w_push = w_hdr || w_body;
  assign w_last = new_in ? w_hdr_rem == '0 : r_rem[w_idx] == RW'(1);
  assign w_proto = w_acc && (!w_vc_ok || (new_in == (w_cur == BODY)));
  assign w_mis = w_hdr && data_in[DL +: addr_length] != addr_length'(my_addr);
  assign w_pop = pop_valid && pop_ready;
  assign w_next_count = w_count + CW'(w_push) - CW'(w_pop);
  assign w_entry = '{data: data_in, vc: vc_no_in, first: new_in, last: w_last};
  always_comb begin
    w_state_n = r_state;
    w_rem_n = r_rem;
    w_any_body = 1'b0;
    if (w_push) begin
      w_state_n[w_idx] = w_last ? IDLE : BODY;
      w_rem_n[w_idx] = w_hdr ? w_hdr_rem : r_rem[w_idx] - RW'(1);
    end
    for (int i = 0; i < no_vc; i++) w_any_body = w_any_body || r_state[i] == BODY;
  end
  always_ff @(posedge clk) begin
    if (!full_reset) begin
      for (int i = 0; i < no_vc; i++) r_state[i] <= IDLE;
      for (int i = 0; i < no_vc; i++) r_rem[i] <= '0;
      r_ready <= 1'b0;
      r_pkt <= '0;
      r_mis <= '0;
      r_err <= '0;
    end else begin
      r_state <= w_state_n;
      r_rem <= w_rem_n;
      r_ready <= w_next_count < CW'(D);
      // Clearing wins over an increment landing in the same cycle.
      r_pkt <= report_reset ? '0 : sat_inc(r_pkt, w_push && w_last);
      r_mis <= report_reset ? '0 : sat_inc(r_mis, w_mis);
      r_err <= report_reset ? '0 : sat_inc(r_err, w_proto);
    end
  end
  phit_fifo #(.DEPTH(D), .WIDTH($bits(entry_t))) u_fifo (
    .clk(clk),
    .i_rst_n(full_reset),
    .i_push(w_push),
    .i_data(w_entry),
    .i_pop(w_pop),
    .o_data(w_head),
    .o_empty(w_empty),
    .o_count(w_count)
  );
  assign ready_out = r_ready;
  assign pop_valid = !w_empty;
  assign pop_data = w_head.data;
  assign pop_vc = w_head.vc;
  assign pop_first = w_head.first;
  assign pop_last = w_head.last;
  assign no_packet_recieve_report = r_pkt;
  assign misroute_report = r_mis;
  assign proto_err_report = r_err;
  assign busy = pop_valid || w_any_body;
endmodule
